// File: rtl/cs_pkg.sv
// Shared constants, state type and command-list address mapping for the RHD2000 register readback.
package cs_pkg;

  localparam logic [1:0] RHD_READ  = 2'b11;
  localparam logic [1:0] RHD_WRITE = 2'b10;
  localparam int         NUM_REGS  = 18;
  localparam int         NUM_EXP   = 14;
  localparam int         NUM_CMDS  = 25;
  localparam logic [5:0] ID_BASE   = 6'd40;

  localparam logic [7:0] INTAN_ID [5] = '{8'h49, 8'h4E, 8'h54, 8'h41, 8'h4E};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FIN
  } cs_state_t;

  // Slots 0..17 read the config regs, 18..22 the ID regs, 23..24 flush the result pipeline.
  function automatic logic [5:0] cmd_addr(input logic [4:0] k, input logic [5:0] dummy);
    if (k < 5'd18)
      return {1'b0, k};
    else if (k < 5'd23)
      return 6'(k) + 6'd22;
    else
      return dummy;
  endfunction

endpackage

// File: rtl/cs_rb_cmdgen.sv
// Maps a command-list index to its RHD READ command word; purely combinational.
module cs_rb_cmdgen
  import cs_pkg::*;
#(
  parameter logic [5:0] DUMMY_REG = 6'd63
) (
  input  logic [4:0]  i_k,
  output logic [15:0] o_cmd
);

  logic [5:0] w_addr;

  assign w_addr = cmd_addr(i_k, DUMMY_REG);
  assign o_cmd  = {RHD_READ, w_addr, 8'h00};

endmodule

// File: rtl/cs_reg_readback.sv
// Reads back RHD2000 registers after configuration and checks them against a snapshot of the config image.
// One command in flight at a time; cmd held stable until cmd_ready, rsp has no backpressure; results lag commands by two.
module cs_reg_readback
  import cs_pkg::*;
#(
  parameter logic [15:0] TIMEOUT   = 16'd1000,
  parameter logic [5:0]  DUMMY_REG = 6'd63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  exp00,
  input  logic [7:0]  exp01,
  input  logic [7:0]  exp02,
  input  logic [7:0]  exp03,
  input  logic [7:0]  exp04,
  input  logic [7:0]  exp05,
  input  logic [7:0]  exp06,
  input  logic [7:0]  exp07,
  input  logic [7:0]  exp08,
  input  logic [7:0]  exp09,
  input  logic [7:0]  exp10,
  input  logic [7:0]  exp11,
  input  logic [7:0]  exp12,
  input  logic [7:0]  exp13,
  input  logic [7:0]  exp_ap,
  output logic [15:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [15:0] rsp_data,
  input  logic        rsp_valid,
  output logic        busy,
  output logic        done,
  output logic [17:0] mismatch,
  output logic        id_ok,
  output logic        timeout,
  output logic        rb_valid,
  output logic [5:0]  rb_addr,
  output logic [7:0]  rb_data
);

  cs_state_t   r_state, w_state_nxt;
  logic [4:0]  r_k;
  logic [15:0] r_timer;
  logic [7:0]  r_snap [NUM_EXP];
  logic [7:0]  r_snap_ap;
  logic [17:0] r_mismatch, w_mismatch_nxt;
  logic [4:0]  r_id_match, w_id_match_nxt;
  logic        r_id_ok;
  logic        r_timeout;
  logic        r_rb_valid;
  logic [5:0]  r_rb_addr;
  logic [7:0]  r_rb_data;

  logic [7:0]  w_exp_in [NUM_EXP];
  logic [15:0] w_cmd;
  logic        w_rsp_take, w_proc, w_last, w_tmo, w_diff, w_is_id;
  logic [5:0]  w_prev_addr;
  logic [7:0]  w_rsp_byte, w_exp_byte;
  logic [2:0]  w_id_idx;
  logic        w_unused_rsp_hi;

  assign w_exp_in = '{exp00, exp01, exp02, exp03, exp04, exp05, exp06,
                      exp07, exp08, exp09, exp10, exp11, exp12, exp13};

  cs_rb_cmdgen #(.DUMMY_REG(DUMMY_REG)) u_cmdgen (
    .i_k   (r_k),
    .o_cmd (w_cmd)
  );

  // The response to command k carries the register addressed by command k-2.
  assign w_rsp_take      = (r_state == ST_WAIT) && rsp_valid;
  assign w_proc          = w_rsp_take && (r_k >= 5'd2);
  assign w_last          = (r_k == 5'(NUM_CMDS - 1));
  assign w_tmo           = (r_timer == TIMEOUT - 16'd1);
  assign w_prev_addr     = cmd_addr(r_k - 5'd2, DUMMY_REG);
  assign w_rsp_byte      = rsp_data[7:0];
  assign w_unused_rsp_hi = ^rsp_data[15:8];
  assign w_id_idx        = 3'(w_prev_addr - ID_BASE);
  assign w_is_id         = (w_prev_addr >= ID_BASE) && (w_prev_addr < ID_BASE + 6'd5);

  always_comb begin
    w_exp_byte = 8'h00;
    if (w_prev_addr < 6'(NUM_EXP))
      w_exp_byte = r_snap[w_prev_addr[3:0]];
    else if (w_prev_addr < 6'(NUM_REGS))
      w_exp_byte = r_snap_ap;
    else if (w_is_id)
      w_exp_byte = INTAN_ID[w_id_idx];
  end

  assign w_diff = (w_rsp_byte != w_exp_byte);

  always_comb begin
    w_mismatch_nxt = r_mismatch;
    w_id_match_nxt = r_id_match;
    if (w_proc) begin
      if (w_prev_addr < 6'(NUM_REGS))
        w_mismatch_nxt[w_prev_addr[4:0]] = w_diff;
      else if (w_is_id)
        w_id_match_nxt[w_id_idx] = !w_diff;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (cmd_ready) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (rsp_valid)
          w_state_nxt = w_last ? ST_FIN : ST_ISSUE;
        else if (w_tmo)
          w_state_nxt = ST_FIN;
      end
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_timer    <= '0;
      for (int i = 0; i < NUM_EXP; i++) r_snap[i] <= '0;
      r_snap_ap  <= '0;
      r_mismatch <= '0;
      r_id_match <= '0;
      r_id_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_rb_valid <= 1'b0;
      r_rb_addr  <= '0;
      r_rb_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rb_valid <= w_proc;
      if (w_proc) begin
        r_rb_addr <= w_prev_addr;
        r_rb_data <= w_rsp_byte;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_EXP; i++) r_snap[i] <= w_exp_in[i];
            r_snap_ap  <= exp_ap;
            r_mismatch <= '0;
            r_id_match <= '0;
            r_id_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_k        <= '0;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) r_timer <= '0;
        end
        ST_WAIT: begin
          r_timer <= r_timer + 16'd1;
          if (rsp_valid) begin
            r_mismatch <= w_mismatch_nxt;
            r_id_match <= w_id_match_nxt;
            // id_ok is resolved with the final ID byte so it is valid alongside done.
            if (w_last)
              r_id_ok <= &w_id_match_nxt;
            else
              r_k <= r_k + 5'd1;
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_valid = (r_state == ST_ISSUE);
  assign cmd_data  = cmd_valid ? w_cmd : 16'h0000;
  assign busy      = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign done      = (r_state == ST_FIN);
  assign mismatch  = r_mismatch;
  assign id_ok     = r_id_ok;
  assign timeout   = r_timeout;
  assign rb_valid  = r_rb_valid;
  assign rb_addr   = r_rb_addr;
  assign rb_data   = r_rb_data;

endmodule

// File: tb/tb_cs_reg_readback.sv
// Bench for cs_reg_readback: SPI chip model with a 2-deep result pipeline plus a list-based checker.
module tb_cs_reg_readback;

  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  e [14];
  logic [7:0]  e_ap;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [15:0] rsp_data = 16'h0;
  logic        rsp_valid = 1'b0;
  logic        busy, done, id_ok, timeout, rb_valid;
  logic [17:0] mismatch;
  logic [5:0]  rb_addr;
  logic [7:0]  rb_data;

  always #5 clk = ~clk;

  cs_reg_readback dut (
    .clk(clk), .rst(rst), .start(start),
    .exp00(e[0]), .exp01(e[1]), .exp02(e[2]), .exp03(e[3]), .exp04(e[4]),
    .exp05(e[5]), .exp06(e[6]), .exp07(e[7]), .exp08(e[8]), .exp09(e[9]),
    .exp10(e[10]), .exp11(e[11]), .exp12(e[12]), .exp13(e[13]), .exp_ap(e_ap),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .busy(busy), .done(done), .mismatch(mismatch), .id_ok(id_ok), .timeout(timeout),
    .rb_valid(rb_valid), .rb_addr(rb_addr), .rb_data(rb_data)
  );

  logic [7:0] chip [64];
  logic [7:0] snap [14];
  logic [7:0] snap_ap;
  logic [7:0] intan [5] = '{8'h49, 8'h4E, 8'h54, 8'h41, 8'h4E};
  int         addr_list[$];
  int         rb_a_q[$];
  logic [7:0] rb_d_q[$];
  int         done_cnt = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  string      g_tag = "";
  int         g_hold_cmd = -1, g_hold_cycles = 0, g_withhold = -1, g_rst_cmd = -1, g_turn_max = 3;
  bit         g_scramble = 1'b0;

  typedef struct {
    int          a1;
    logic [7:0]  v1;
    int          a2;
    logic [7:0]  v2;
    logic [17:0] mm;
    bit          id;
  } vec_t;
  vec_t vecs [5];

  always @(negedge clk) begin
    if (rb_valid) begin
      rb_a_q.push_back(int'(rb_addr));
      rb_d_q.push_back(rb_data);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h", g_tag, name, act, req);
  endtask

  function automatic logic [7:0] exp_of(input int a);
    if (a < 14) return snap[a];
    if (a < 18) return snap_ap;
    return intan[a - 40];
  endfunction

  task automatic load_chip();
    for (int a = 0; a < 64; a++) chip[a] = 8'($urandom);
    for (int a = 0; a < 14; a++) chip[a] = e[a];
    for (int a = 14; a < 18; a++) chip[a] = e_ap;
    for (int i = 0; i < 5; i++) chip[40 + i] = intan[i];
  endtask

  task automatic check_zero_outputs();
    check("rst cmd_data", cmd_data, 0);
    check("rst cmd_valid", cmd_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst mismatch", mismatch, 0);
    check("rst id_ok", id_ok, 0);
    check("rst timeout", timeout, 0);
    check("rst rb_valid", rb_valid, 0);
    check("rst rb_addr", rb_addr, 0);
    check("rst rb_data", rb_data, 0);
  endtask

  task automatic run_pass();
    int t, c, d0, resp_cnt, a;
    bit timed_out, aborted;
    logic [17:0] mm_exp;
    bit id_exp;
    resp_cnt = 0; timed_out = 0; aborted = 0;
    rb_a_q.delete(); rb_d_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 14; i++) snap[i] = e[i];
    snap_ap = e_ap;
    @(negedge clk);
    start = 1'b0;
    if (g_scramble) begin
      for (int i = 0; i < 14; i++) e[i] = 8'($urandom);
      e_ap = 8'($urandom);
    end
    for (int n = 0; n < 25; n++) begin
      t = 0;
      while (!cmd_valid && t < 50) begin @(negedge clk); t++; end
      check("cmd_valid", cmd_valid, 1);
      if (!cmd_valid) begin aborted = 1; break; end
      check("cmd_data", cmd_data, {2'b11, 6'(addr_list[n]), 8'h00});
      if (n == g_hold_cmd) begin
        for (int h = 0; h < g_hold_cycles; h++) begin
          if (h == 1) start = 1'b1;
          if (h == 2) start = 1'b0;
          if (h == 3) begin rsp_valid = 1'b1; rsp_data = 16'h55AA; end
          if (h == 4) rsp_valid = 1'b0;
          @(negedge clk);
          check("hold valid", cmd_valid, 1);
          check("hold data", cmd_data, 16'hC300);
        end
        start = 1'b0; rsp_valid = 1'b0;
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      if (n == g_rst_cmd) begin
        check("busy before rst", busy, 1);
        #2 rst = 1'b1;
        #1 check_zero_outputs();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (n == g_withhold) begin
        c = 0;
        while (!timeout && c < 2 * TMO) begin @(negedge clk); c++; end
        check("timeout latency", c, TMO);
        check("timeout done", done, 1);
        check("timeout busy", busy, 0);
        timed_out = 1;
        break;
      end
      repeat ($urandom_range(g_turn_max, 0)) @(negedge clk);
      rsp_valid = 1'b1;
      rsp_data  = {8'($urandom), (n >= 2) ? chip[addr_list[n - 2]] : 8'($urandom)};
      @(negedge clk);
      rsp_valid = 1'b0;
      resp_cnt++;
    end
    if (aborted) return;
    t = 0;
    while (done_cnt == d0 && t < 10) begin @(negedge clk); t++; end
    @(negedge clk);
    rsp_valid = 1'b1; rsp_data = 16'hFF00;
    @(negedge clk);
    rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    mm_exp = '0;
    for (int j = 2; j < resp_cnt; j++) begin
      a = addr_list[j - 2];
      if (a < 18 && chip[a] != exp_of(a)) mm_exp[a] = 1'b1;
    end
    id_exp = (resp_cnt == 25);
    for (int i = 0; i < 5; i++) if (chip[40 + i] != intan[i]) id_exp = 0;
    check("done pulses", done_cnt - d0, 1);
    check("busy idle", busy, 0);
    check("timeout flag", timeout, timed_out);
    check("mismatch", mismatch, mm_exp);
    check("id_ok", id_ok, id_exp);
    check("rb count", rb_a_q.size(), (resp_cnt > 2) ? resp_cnt - 2 : 0);
    for (int i = 0; i < rb_a_q.size() && i < 23; i++) begin
      check("rb_addr", rb_a_q[i], addr_list[i]);
      check("rb_data", rb_d_q[i], chip[addr_list[i]]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 18; a++) addr_list.push_back(a);
    for (int a = 40; a < 45; a++) addr_list.push_back(a);
    addr_list.push_back(63);
    addr_list.push_back(63);

    e = '{8'hDE, 8'h20, 8'h28, 8'h02, 8'h9C, 8'h00, 8'h80, 8'h00,
          8'h26, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    e_ap = 8'hFF;

    vecs[0] = '{-1, 8'h00, -1, 8'h00, 18'h00000, 1'b1};
    vecs[1] = '{ 1, 8'h21, 15, 8'hFE, 18'h08002, 1'b1};
    vecs[2] = '{42, 8'h4F, -1, 8'h00, 18'h00000, 1'b0};
    vecs[3] = '{ 0, 8'h01, 44, 8'h00, 18'h00001, 1'b0};
    vecs[4] = '{13, 8'h55, 17, 8'h00, 18'h22000, 1'b1};

    g_tag = "reset";
    repeat (3) @(negedge clk);
    check_zero_outputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      g_tag = $sformatf("vec%0d", v);
      load_chip();
      if (vecs[v].a1 >= 0) chip[vecs[v].a1] = vecs[v].v1;
      if (vecs[v].a2 >= 0) chip[vecs[v].a2] = vecs[v].v2;
      run_pass();
      check("table mismatch", mismatch, vecs[v].mm);
      check("table id_ok", id_ok, vecs[v].id);
    end

    g_tag = "withhold";
    load_chip();
    chip[1] = 8'h00;
    g_withhold = 5;
    run_pass();
    g_withhold = -1;

    g_tag = "hold_ready";
    load_chip();
    g_hold_cmd = 3; g_hold_cycles = 7;
    run_pass();
    g_hold_cmd = -1;

    g_tag = "mid_rst";
    load_chip();
    chip[0] = 8'h00;
    g_rst_cmd = 6;
    run_pass();
    g_rst_cmd = -1;
    g_tag = "post_rst";
    load_chip();
    run_pass();

    g_scramble = 1'b1;
    for (int r = 0; r < 4; r++) begin
      g_tag = $sformatf("rand%0d", r);
      for (int i = 0; i < 14; i++) e[i] = 8'($urandom);
      e_ap = 8'($urandom);
      load_chip();
      for (int a = 0; a < 45; a++)
        if ((a < 18 || a >= 40) && $urandom_range(3, 0) == 0)
          chip[a] = chip[a] ^ 8'($urandom_range(255, 1));
      run_pass();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cs_reg_readback.md
Name: cs_reg_readback

Overview:
- Reads back the RHD2000 configuration registers after configuration and checks them against the register image the config block produced (reg00..reg13, regap).
- Issues READ commands over the 16-bit command/result port of the SPI engine and accounts for the chip's 2-command result pipeline.
- Streams each read-back byte, and reports a per-register mismatch mask plus an INTAN chip-ID check.
- Sits between the config register block and the SPI master; it is the read side of the config write path.

Parameters:
- TIMEOUT, 16'd1000, cycles allowed from command acceptance to its result strobe before aborting.
- DUMMY_REG, 6'd63, register addressed by the two trailing pipeline-flush READs.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a readback pass
- exp00..exp13  in  8 each  expected values for registers 0..13
- exp_ap  in  8  expected value for registers 14..17 (amplifier power)
- cmd_data  out  16  SPI command word
- cmd_valid  out  1  command valid
- cmd_ready  in  1  SPI engine accepts cmd_data this cycle
- rsp_data  in  16  SPI result word
- rsp_valid  in  1  one-cycle result strobe; exactly one per accepted command, in order, no backpressure
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at the end of a pass (normal or timeout)
- mismatch  out  18  bit n set when register n read-back differs from expected
- id_ok  out  1  registers 40..44 read as "INTAN" (0x49,0x4E,0x54,0x41,0x4E)
- timeout  out  1  last pass aborted on timeout
- rb_valid  out  1  one-cycle strobe per decoded read-back byte
- rb_addr  out  6  register address of rb_data
- rb_data  out  8  read-back byte (rsp_data[7:0])

Behaviour:
- Reset (asynchronous): all outputs 0. State is IDLE, counters are 0, and the snapshot is cleared.
- Command list, index k = 0..24:
  - k = 0..17: READ reg k.
  - k = 18..22: READ reg 40..44.
  - k = 23, 24: READ DUMMY_REG.
- READ encoding: cmd_data = {2'b11, addr[5:0], 8'h00}.
- Result pipeline: the result for command k arrives with the response to command k+2.
  - Responses j = 0 and 1 are discarded.
  - Response j (2..24) carries the register addressed by command j-2.
- FSM states: IDLE, ISSUE, WAIT, FIN.
  - IDLE: on start, snapshot exp00..exp13 and exp_ap. Clear mismatch, timeout and id_ok. Set k = 0 and busy = 1, then go to ISSUE. start while busy is ignored.
  - ISSUE: cmd_valid = 1 and cmd_data stays stable until cmd_ready. On the cmd_valid && cmd_ready cycle, drop cmd_valid, clear the timer and go to WAIT.
  - WAIT: the timer increments each cycle. On rsp_valid:
    - If j ≥ 2, process the byte.
    - If k = 24, go to FIN; otherwise k++ and go to ISSUE.
    - If the timer reaches TIMEOUT first, set timeout = 1 and go to FIN.
  - FIN: done = 1 for one cycle, busy = 0, back to IDLE. mismatch, id_ok and timeout hold until the next start.
- Byte processing, for address a = command address of j-2:
  - rb_valid/rb_addr/rb_data are registered, asserted the cycle after rsp_valid.
  - For a = 0..13: mismatch[a] = (rsp_data[7:0] != snapshot exp_a).
  - For a = 14..17: compare against exp_ap.
  - For a = 40..44: compare against the INTAN character; id_ok = all five matched, and is set at FIN.
- rsp_data[15:8] is ignored.
- rsp_valid outside WAIT is ignored, with no state change.
- If cmd_ready and rsp_valid arrive in the same cycle while in ISSUE, the response is ignored (the protocol forbids it).
- On timeout, mismatch keeps the bits evaluated so far. id_ok = 0.
- Latency: one pass takes at least 25 × (1 + SPI turnaround) cycles.

Decomposition:
- Shared package cs_pkg:
  - RHD READ/WRITE opcode constants (2'b11 / 2'b10).
  - Register-count constant (18).
  - The INTAN ID byte array.
  - The FSM state typedef.
- Sub-module cs_rb_cmdgen: a combinational mapping from k to address and cmd_data. It is small enough to keep inline if preferred.

Test Plan:
- Expected image from all-zero eth_cmd (exp01 = 0x20, exp02 = 0x28, exp08 = 0x26, exp_ap = 0xFF, others per table); SPI model echoes identical values plus INTAN → 25 commands issued, done after the last response, mismatch = 0, id_ok = 1, 23 rb_valid strobes with rb_addr 0..17 then 40..44.
- Same run, but the model returns 0x21 for register 1 and 0xFE for register 15 → mismatch = 18'h08002, id_ok = 1.
- Model returns 0x4F at register 42 → id_ok = 0, mismatch = 0.
- Model withholds the response after command 5 → timeout = 1 exactly TIMEOUT cycles after acceptance, done pulses, busy = 0.
- cmd_ready held low for 7 cycles on command 3 → cmd_data stays 16'hC300 and stable; second start pulse while busy is ignored.
- rst asserted mid-WAIT → all outputs 0 immediately (asynchronous); a following start performs a full clean pass.
